alu_chain: RTL and testbench
============================

ALU_CHAIN -- requirements
Module: alu_chain

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits (4 bytes), ALU slice width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new multi-byte operation; sampled only in IDLE.
REQ-005 op_in  input  4  ALU opcode for the whole operation.
REQ-006 width  input  2  operand length minus one: 0=8b, 1=16b, 2=24b, 3=32b.
REQ-007 a_in, b_in  input  32 each  operands; byte 0 = bits 7:0.
REQ-008 cin_in  input  1  carry into byte 0.
REQ-009 alu_a, alu_b  output  8 each  byte operands driven to the external 8-bit alu.
REQ-010 alu_op  output  4  opcode driven to the alu.
REQ-011 alu_cin  output  1  carry driven to the alu.
REQ-012 alu_q  input  8; alu_cout  input  1  combinational alu result for the current byte.
REQ-013 busy  output  1  high while bytes are being processed.
REQ-014 done  output  1  one-cycle pulse: result and cout valid.
REQ-015 result  output  32  assembled result; bytes above the requested width read 0.
REQ-016 cout  output  1  carry out of the most significant processed byte.

Function
REQ-017 Three states: IDLE, RUN, DONE.
REQ-018 IDLE & start=1 at an edge: latch a_in, b_in, op_in, cin_in (into carry register), nbytes=width+1; clear byte index to 0; clear result to 0; go RUN.
REQ-019 IDLE & start=0: remain IDLE; result and cout hold their last values.
REQ-020 RUN combinational outputs: alu_a = latched a byte[index], alu_b = latched b byte[index], alu_cin = carry register, alu_op = latched op.
REQ-021 RUN at each edge: result byte[index] <= alu_q; carry register <= alu_cout; index <= index+1.
REQ-022 RUN with index = nbytes-1 at an edge: perform REQ-021, cout <= alu_cout, go DONE.
REQ-023 DONE: done=1 for exactly one cycle, then unconditionally IDLE at next edge.
REQ-024 Latency: start sampled at edge 0 -> RUN for nbytes cycles -> done high in the cycle after edge nbytes; width=0 gives done after edge 1.
REQ-025 busy=1 in RUN only; 0 in IDLE and DONE.
REQ-026 start while in RUN or DONE is ignored (not queued); a start held high through DONE is accepted on the first IDLE edge.
REQ-027 In IDLE and DONE, alu_a=0, alu_b=0, alu_cin=0; alu_op = last latched op.
REQ-028 Inputs a_in, b_in, op_in, width, cin_in changing during RUN have no effect on the operation in flight.
REQ-029 Index never exceeds 3; no wrap-around into unused bytes.

Reset
REQ-030 rst=1 at an edge: state IDLE, index 0, carry register 0, result 0, cout 0, done 0, busy 0, latched op 0.
REQ-031 rst has priority over start and aborts any operation in RUN or DONE; no done pulse follows the abort.

Verification
REQ-032 Bench pairs alu_chain with a behavioural alu stub: op 0 = add, q={cout,q}=a+b+cin; op 1 = AND, cout=0.
REQ-033 Reset: rst high one edge -> busy=0, done=0, result=0x00000000, cout=0.
REQ-034 8-bit add: width=0, a=21, b=7, cin=0, op=0, start -> busy 1 cycle, done next cycle, result=0x0000001C, cout=0.
REQ-035 32-bit carry ripple: width=3, a=0xFFFFFFFF, b=0x00000001, cin=0 -> busy 4 cycles, done, result=0x00000000, cout=1.
REQ-036 16-bit with cin, ignored start: width=1, a=0x00FF, b=0x0000, cin=1, start held high -> result=0x00000100, cout=0; second op begins on first IDLE edge after done.
REQ-037 Abort: 32-bit op=1 started, rst asserted after 2 RUN edges -> IDLE, result=0, no done pulse; new 8-bit AND 0xF0&0x3C then gives result=0x00000030.

Source files
------------

// File: rtl/alu_chain.sv
// Multi-byte operation sequencer around an external combinational 8-bit ALU.
// Walks the operand bytes LSB first, chaining the carry, and assembles a 32-bit result.
module alu_chain (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op_in,
  input  logic [1:0]  width,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        cin_in,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_cin,
  input  logic [7:0]  alu_q,
  input  logic        alu_cout,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  op_q, op_d;
  logic        carry_q, carry_d;
  logic        cout_q, cout_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  last_q, last_d;

  logic [7:0]  a_bytes [4];
  logic [7:0]  b_bytes [4];
  logic [31:0] result_run;

  // Byte lanes: operand slices and the result with the current lane replaced by alu_q.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign a_bytes[gi] = a_q[gi*8 +: 8];
    assign b_bytes[gi] = b_q[gi*8 +: 8];
    assign result_run[gi*8 +: 8] = (idx_q == 2'(gi)) ? alu_q : result_q[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    idx_d    = idx_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a_in;
          b_d      = b_in;
          op_d     = op_in;
          carry_d  = cin_in;
          last_d   = width;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d = result_run;
        carry_d  = alu_cout;
        // The index holds on the final byte so it never wraps past lane 3.
        if (idx_q == last_q) begin
          cout_d  = alu_cout;
          state_d = DONE;
        end else begin
          idx_d = 2'(idx_q + 2'd1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    alu_op  = op_q;
    alu_a   = busy ? a_bytes[idx_q] : 8'h00;
    alu_b   = busy ? b_bytes[idx_q] : 8'h00;
    alu_cin = busy ? carry_q : 1'b0;
    result  = result_q;
    cout    = cout_q;
  end

endmodule

// File: tb/tb_alu_chain.sv
// Bench for alu_chain with a behavioural 8-bit ALU stub (op 0 = add, op 1 = AND).
// Table-driven vectors plus hand sequences for held start and abort; scoreboard on done.
module tb_alu_chain;

  logic        clk = 1'b0;
  logic        rst, start, cin_in, alu_cin, alu_cout, busy, done, cout;
  logic [3:0]  op_in, alu_op;
  logic [1:0]  width;
  logic [31:0] a_in, b_in, result;
  logic [7:0]  alu_a, alu_b, alu_q;
  logic [8:0]  sum;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [1:0]  w;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] res;
    logic        co;
    int          cyc;
  } vec_t;

  vec_t        vecs [7];
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  alu_chain dut (
    .clk(clk), .rst(rst), .start(start), .op_in(op_in), .width(width),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_q(alu_q), .alu_cout(alu_cout),
    .busy(busy), .done(done), .result(result), .cout(cout)
  );

  always_comb begin
    sum      = 9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
    alu_q    = 8'h00;
    alu_cout = 1'b0;
    case (alu_op)
      4'd0: {alu_cout, alu_q} = sum;
      4'd1: alu_q = alu_a & alu_b;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Waits for done (bounded), counting busy cycles; pops the scoreboard on done.
  task automatic wait_done(input string tag, output int cycles);
    logic        got;
    logic [32:0] e;
    cycles = 0;
    got    = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (busy) cycles++;
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      total++;
      $display("FAIL %s_timeout: got no done, expected done within 20 cycles", tag);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 64'(result), 64'(e[31:0]));
      check({tag, "_cout"}, 64'(cout), 64'(e[32]));
      $display("op %s: result=0x%08h cout=%0d busy_cycles=%0d", tag, result, cout, cycles);
    end
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int cycles;
    @(negedge clk);
    width = v.w; op_in = v.op; a_in = v.a; b_in = v.b; cin_in = v.cin; start = 1'b1;
    exp_q.push_back({v.co, v.res});
    @(negedge clk);
    start = 1'b0;
    check({tag, "_alu_a0"}, 64'(alu_a), 64'(v.a[7:0]));
    check({tag, "_alu_cin0"}, 64'(alu_cin), 64'(v.cin));
    // Scramble inputs while the operation is in flight.
    a_in = $urandom; b_in = $urandom; op_in = 4'($urandom); width = 2'($urandom); cin_in = 1'($urandom);
    wait_done(tag, cycles);
    check({tag, "_cycles"}, 64'(cycles), 64'(v.cyc));
    @(negedge clk);
    check({tag, "_idle_done"}, 64'(done), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_alu"}, {54'd0, alu_a, alu_b, alu_cin, alu_op[0]}, {54'd0, 8'h00, 8'h00, 1'b0, v.op[0]});
    @(negedge clk);
    check({tag, "_hold"}, 64'(result), 64'(v.res));
  endtask

  initial begin
    int cycles;
    int done_seen;
    vecs[0] = '{2'd0, 4'd0, 32'd21,        32'd7,         1'b0, 32'h0000001C, 1'b0, 1};
    vecs[1] = '{2'd3, 4'd0, 32'hFFFFFFFF,  32'h00000001,  1'b0, 32'h00000000, 1'b1, 4};
    vecs[2] = '{2'd1, 4'd0, 32'h000000FF,  32'h00000000,  1'b1, 32'h00000100, 1'b0, 2};
    vecs[3] = '{2'd2, 4'd0, 32'h12345678,  32'h11111111,  1'b0, 32'h00456789, 1'b0, 3};
    vecs[4] = '{2'd3, 4'd1, 32'hF0F0F0F0,  32'hFF00FF00,  1'b1, 32'hF000F000, 1'b0, 4};
    vecs[5] = '{2'd1, 4'd0, 32'hABCD8000,  32'h00008000,  1'b0, 32'h00000000, 1'b1, 2};
    vecs[6] = '{2'd0, 4'd0, 32'h000000FF,  32'h00000001,  1'b1, 32'h00000001, 1'b1, 1};

    // Reset with start asserted: reset must win.
    rst = 1'b1; start = 1'b1; op_in = 4'd1; width = 2'd3; a_in = '1; b_in = '1; cin_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);

    for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Start held high through RUN and DONE; second op begins on first IDLE edge.
    @(negedge clk);
    width = 2'd1; op_in = 4'd0; a_in = 32'h000000FF; b_in = 32'h0; cin_in = 1'b1; start = 1'b1;
    exp_q.push_back({1'b0, 32'h00000100});
    @(negedge clk);
    wait_done("held1", cycles);
    check("held1_cycles", 64'(cycles), 64'd2);
    width = 2'd0; a_in = 32'd3; b_in = 32'd4; cin_in = 1'b0;
    exp_q.push_back({1'b0, 32'h00000007});
    @(negedge clk);
    check("held_idle_busy", 64'(busy), 64'd0);
    check("held_idle_done", 64'(done), 64'd0);
    @(negedge clk);
    check("held_accept_busy", 64'(busy), 64'd1);
    start = 1'b0;
    @(negedge clk);
    wait_done("held2", cycles);
    @(negedge clk);

    // Abort a 32-bit AND after two RUN edges.
    width = 2'd3; op_in = 4'd1; a_in = 32'hFFFFFFFF; b_in = 32'h12345678; cin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("abort_partial", 64'(result), 64'h00005678);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy_after", 64'(busy), 64'd0);
    check("abort_done_after", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    check("abort_alu_op", 64'(alu_op), 64'd0);
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    run_op("after_abort", '{2'd0, 4'd1, 32'h000000F0, 32'h0000003C, 1'b0, 32'h00000030, 1'b0, 1});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
